// File: rtl/dct_rle_encoder.sv
// Quantizing run-length encoder: (run, level) tokens plus one EOB per block.
// Optional macro RLE_SAT_EN clamps levels instead of wrapping them.
module dct_rle_encoder #(
  parameter int COEF_W    = 18,
  parameter int LEVEL_W   = 10,
  parameter int SHIFT     = 6,
  parameter int BLOCK_LEN = 8,
  parameter int RUN_W     = $clog2(BLOCK_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COEF_W-1:0]  coef_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RUN_W-1:0]   out_run,
  output logic [LEVEL_W-1:0] out_level,
  output logic               out_eob
);

  localparam int QW = COEF_W - SHIFT + 1;

  typedef enum logic {
    RUN,
    EOB_PEND
  } state_e;

  state_e             state_q, state_d;
  logic [RUN_W-1:0]   idx_q, idx_d;
  logic [RUN_W-1:0]   zrun_q, zrun_d;
  logic               vld_q, vld_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [LEVEL_W-1:0] lvl_q, lvl_d;
  logic               eob_q, eob_d;

  logic               neg;
  logic [COEF_W:0]    mag;
  logic [QW-1:0]      mag_sh;
  logic [QW-1:0]      q_full;
  logic [LEVEL_W-1:0] lvl;
  logic               acc;
  logic               xfer;
  logic               last;

  // Sign-magnitude shift truncates toward zero for both signs.
  assign neg    = coef_in[COEF_W-1];
  assign mag    = neg ? -{coef_in[COEF_W-1], coef_in}
                      : {1'b0, coef_in};
  assign mag_sh = QW'(mag >> SHIFT);
  assign q_full = neg ? -mag_sh : mag_sh;

`ifdef RLE_SAT_EN
  localparam logic signed [QW-1:0] LMAX =
    QW'((1 << (LEVEL_W-1)) - 1);
  localparam logic signed [QW-1:0] LMIN =
    QW'(-(1 << (LEVEL_W-1)));

  always_comb begin
    lvl = q_full[LEVEL_W-1:0];
    if ($signed(q_full) > LMAX) begin
      lvl = LMAX[LEVEL_W-1:0];
    end else if ($signed(q_full) < LMIN) begin
      lvl = LMIN[LEVEL_W-1:0];
    end
  end
`else
  assign lvl = LEVEL_W'(q_full);
`endif

  assign in_ready = (state_q == RUN) && (!vld_q || out_ready);
  assign acc      = in_valid && in_ready;
  assign xfer     = vld_q && out_ready;
  assign last     = idx_q == RUN_W'(BLOCK_LEN - 1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    zrun_d  = zrun_q;
    vld_d   = vld_q;
    run_d   = run_q;
    lvl_d   = lvl_q;
    eob_d   = eob_q;
    if (xfer) begin
      vld_d = 1'b0;
    end
    unique case (state_q)
      RUN: begin
        if (acc) begin
          idx_d = idx_q + RUN_W'(1);
          if (lvl != '0) begin
            vld_d  = 1'b1;
            run_d  = zrun_q;
            lvl_d  = lvl;
            eob_d  = 1'b0;
            zrun_d = '0;
            if (last) begin
              state_d = EOB_PEND;
            end
          end else if (last) begin
            vld_d  = 1'b1;
            run_d  = '0;
            lvl_d  = '0;
            eob_d  = 1'b1;
            zrun_d = '0;
          end else begin
            zrun_d = zrun_q + RUN_W'(1);
          end
        end
      end
      EOB_PEND: begin
        // EOB replaces the final level token as it leaves.
        if (xfer) begin
          vld_d   = 1'b1;
          run_d   = '0;
          lvl_d   = '0;
          eob_d   = 1'b1;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      idx_q   <= '0;
      zrun_q  <= '0;
      vld_q   <= 1'b0;
      run_q   <= '0;
      lvl_q   <= '0;
      eob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      zrun_q  <= zrun_d;
      vld_q   <= vld_d;
      run_q   <= run_d;
      lvl_q   <= lvl_d;
      eob_q   <= eob_d;
    end
  end

  assign out_valid = vld_q;
  assign out_run   = run_q;
  assign out_level = lvl_q;
  assign out_eob   = eob_q;

endmodule

// File: tb/tb_dct_rle_encoder.sv
// Directed bench for dct_rle_encoder; expected tokens are hand-computed.
// Build with RLE_SAT_EN defined to check the clamping variant.
module tb_dct_rle_encoder;

  localparam int COEF_W  = 18;
  localparam int LEVEL_W = 10;
  localparam int RUN_W   = 3;

  typedef struct packed {
    logic [RUN_W-1:0]   run;
    logic [LEVEL_W-1:0] level;
    logic               eob;
  } tok_t;

  typedef int blk_t [8];

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [COEF_W-1:0]  coef_in;
  logic               out_valid;
  logic               out_ready;
  logic [RUN_W-1:0]   out_run;
  logic [LEVEL_W-1:0] out_level;
  logic               out_eob;

  tok_t toks[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   acc_cnt = 0;
  int   last_wait = 0;

  dct_rle_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef_in   (coef_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_run   (out_run),
    .out_level (out_level),
    .out_eob   (out_eob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) begin
      toks.push_back('{run: out_run, level: out_level,
                       eob: out_eob});
    end
    if (!reset && in_valid && in_ready) begin
      acc_cnt++;
    end
  end

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int c);
    int   n;
    logic ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    coef_in = 18'(c);
    while (!ok && n < 50) begin
      @(posedge clk);
      ok = in_ready;
      n++;
    end
    #1;
    last_wait = n;
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end
  endtask

  task automatic send_blk(input blk_t b);
    for (int i = 0; i < 8; i++) begin
      send(b[i]);
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic exp_tok(input string tag, input int run,
                         input int level, input int eob);
    tok_t t;
    if (toks.size() == 0) begin
      chk({tag, "_missing"}, 0, 1);
    end else begin
      t = toks.pop_front();
      chk({tag, "_run"}, int'(t.run), run);
      chk({tag, "_lvl"}, int'($signed(t.level)), level);
      chk({tag, "_eob"}, int'(t.eob), eob);
    end
  endtask

  task automatic exp_none(input string tag);
    chk({tag, "_extra"}, toks.size(), 0);
    toks.delete();
  endtask

  int rnd_c [6] = '{63, -63, 64, -64, 127, -127};
  int rnd_l [6] = '{0, 0, 1, -1, 1, -1};
  int a0;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    coef_in = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_valid", int'(out_valid), 0);
    chk("rst_run", int'(out_run), 0);
    chk("rst_level", int'(out_level), 0);
    chk("rst_eob", int'(out_eob), 0);
    chk("rst_ready", int'(in_ready), 1);

    // All-zero block: single EOB right after the 8th accept.
    send_blk('{0, 0, 0, 0, 0, 0, 0, 0});
    chk("zero_vld", int'(out_valid), 1);
    chk("zero_eob", int'(out_eob), 1);
    drain();
    exp_tok("zero", 0, 0, 1);
    exp_none("zero");

    send_blk('{640, 0, 0, -128, 0, 0, 0, 0});
    drain();
    exp_tok("mix0", 0, 10, 0);
    exp_tok("mix1", 2, -2, 0);
    exp_tok("mix2", 0, 0, 1);
    exp_none("mix");

    // Nonzero last coefficient: level token, bubble, then EOB.
    for (int i = 0; i < 7; i++) begin
      send(0);
    end
    send(64);
    chk("last_vld", int'(out_valid), 1);
    chk("last_run", int'(out_run), 7);
    chk("last_lvl", int'($signed(out_level)), 1);
    chk("last_rdy", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("last_eob_vld", int'(out_valid), 1);
    chk("last_eob", int'(out_eob), 1);
    chk("last_eob_rdy", int'(in_ready), 1);
    send(0);
    chk("next_idx0_wait", last_wait, 1);
    for (int i = 0; i < 7; i++) begin
      send(0);
    end
    drain();
    exp_tok("last0", 7, 1, 0);
    exp_tok("last1", 0, 0, 1);
    exp_tok("last2", 0, 0, 1);
    exp_none("last");

    for (int k = 0; k < 6; k++) begin
      send_blk('{rnd_c[k], 0, 0, 0, 0, 0, 0, 0});
      drain();
      if (rnd_l[k] != 0) begin
        exp_tok("rnd_lv", 0, rnd_l[k], 0);
      end
      exp_tok("rnd_eob", 0, 0, 1);
      exp_none("rnd");
    end

    // Backpressure with a pending token.
    out_ready = 1'b0;
    send(640);
    chk("bp_vld0", int'(out_valid), 1);
    coef_in = '0;
    a0 = acc_cnt;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_vld", int'(out_valid), 1);
      chk("bp_run", int'(out_run), 0);
      chk("bp_lvl", int'($signed(out_level)), 10);
      chk("bp_eob", int'(out_eob), 0);
      chk("bp_rdy", int'(in_ready), 0);
    end
    chk("bp_no_acc", acc_cnt, a0);
    out_ready = 1'b1;
    send(0);
    chk("bp_resume_wait", last_wait, 1);
    chk("bp_resume_acc", acc_cnt, a0 + 1);
    for (int i = 0; i < 6; i++) begin
      send(0);
    end
    drain();
    exp_tok("bp0", 0, 10, 0);
    exp_tok("bp1", 0, 0, 1);
    exp_none("bp");

    send_blk('{131071, 0, 0, 0, 0, 0, 0, 0});
    drain();
`ifdef RLE_SAT_EN
    exp_tok("satp", 0, 511, 0);
`else
    exp_tok("satp", 0, -1, 0);
`endif
    exp_tok("satp_eob", 0, 0, 1);
    exp_none("satp");

    send_blk('{-131072, 0, 0, 0, 0, 0, 0, 0});
    drain();
`ifdef RLE_SAT_EN
    exp_tok("satn", 0, -512, 0);
`endif
    exp_tok("satn_eob", 0, 0, 1);
    exp_none("satn");

    // Reset mid-block with a token pending.
    send(0);
    send(0);
    send(640);
    chk("mid_pend", int'(out_valid), 1);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_vld", int'(out_valid), 0);
    chk("mid_rdy", int'(in_ready), 1);
    drain();
    exp_none("mid");
    send_blk('{0, 0, 0, 0, 0, 0, 0, 192});
    drain();
    exp_tok("post0", 7, 3, 0);
    exp_tok("post1", 0, 0, 1);
    exp_none("post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
